// File: rtl/byte_stream_packer.sv
// Byte-lane stream packer: packs LANES-byte beats little-endian into a SIZE_IN_BYTES word
// behind a registered valid/ready output stage. Optional macro: BYTE_STREAM_PACKER_ZERO_FILL_EN.
module byte_stream_packer #(
  parameter int SIZE_IN_BYTES = 13,
  parameter int BYTE_NUM_SIZE = 4,
  parameter int LANES         = 1
) (
  input  logic                       CLK,
  input  logic                       ARESET,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [LANES*8-1:0]         IN_DATA,
  input  logic                       IN_LAST,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [SIZE_IN_BYTES*8-1:0] OUT_VALUE,
  output logic [BYTE_NUM_SIZE-1:0]   OUT_BYTE_COUNT
);

  localparam int WORD_W = SIZE_IN_BYTES * 8;
  localparam int BEATS  = SIZE_IN_BYTES / LANES;
  localparam logic [BYTE_NUM_SIZE-1:0] LANES_C = BYTE_NUM_SIZE'(LANES);
  localparam logic [BYTE_NUM_SIZE-1:0] SIZE_C  = BYTE_NUM_SIZE'(SIZE_IN_BYTES);

  typedef enum logic {
    S_FILLING = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [BYTE_NUM_SIZE-1:0] r_ptr;
  logic [BYTE_NUM_SIZE-1:0] w_ptr_next;
  logic [BYTE_NUM_SIZE-1:0] w_ptr_sum;
  logic [WORD_W-1:0]        r_fill;
  logic [WORD_W-1:0]        w_fill_merged;
  logic [WORD_W-1:0]        w_fill_next;
  logic                     r_out_valid;
  logic                     w_out_valid_next;
  logic [WORD_W-1:0]        r_out_value;
  logic [WORD_W-1:0]        w_out_value_next;
  logic [BYTE_NUM_SIZE-1:0] r_out_count;
  logic [BYTE_NUM_SIZE-1:0] w_out_count_next;
  logic                     w_accept;
  logic                     w_complete;
  logic                     w_out_free;
  logic                     w_transfer;

  // Ready depends on the state flop only; OUT_READY never reaches IN_READY.
  assign IN_READY   = (r_state == S_FILLING) && !ARESET;
  assign w_accept   = IN_VALID && IN_READY;
  assign w_ptr_sum  = r_ptr + LANES_C;
  assign w_complete = (w_ptr_sum == SIZE_C) || IN_LAST;
  assign w_out_free = !r_out_valid || OUT_READY;

  // PTR is always a multiple of LANES, so one lane group is selected per beat.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_fill_merged = r_fill;
    for (int b = 0; b < BEATS; b++) begin
      if (r_ptr == BYTE_NUM_SIZE'(b * LANES)) begin
        w_fill_merged[b*LANES*8 +: LANES*8] = IN_DATA;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_fill_next      = r_fill;
    w_transfer       = 1'b0;
    w_out_value_next = r_out_value;
    w_out_count_next = r_out_count;

    case (r_state)
      S_FILLING: begin
        if (w_accept) begin
          w_fill_next = w_fill_merged;
          w_ptr_next  = w_ptr_sum;
          if (w_complete) begin
            if (w_out_free) begin
              w_transfer       = 1'b1;
              w_out_value_next = w_fill_merged;
              w_out_count_next = w_ptr_sum;
              w_ptr_next       = '0;
            end else begin
              // PTR parks at the word's byte count until the output frees.
              w_state_next = S_PENDING;
            end
          end
        end
      end
      S_PENDING: begin
        if (w_out_free) begin
          w_transfer       = 1'b1;
          w_out_value_next = r_fill;
          w_out_count_next = r_ptr;
          w_ptr_next       = '0;
          w_state_next     = S_FILLING;
        end
      end
      default: w_state_next = S_FILLING;
    endcase

`ifdef BYTE_STREAM_PACKER_ZERO_FILL_EN
    if (w_transfer) begin
      w_fill_next = '0;
    end
`endif
  end

  assign w_out_valid_next = w_transfer ? 1'b1 : (OUT_READY ? 1'b0 : r_out_valid);

  // NOTE: the fill buffer is a plain register bank, so it is reset like any other state here.
  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= S_FILLING;
      r_ptr       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_fill      <= w_fill_next;
      r_out_valid <= w_out_valid_next;
      r_out_value <= w_out_value_next;
      r_out_count <= w_out_count_next;
    end
  end

  assign OUT_VALID      = r_out_valid;
  assign OUT_VALUE      = r_out_value;
  assign OUT_BYTE_COUNT = r_out_count;

endmodule
